// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: parser state encoding, byte type and default header bytes.
package uart_frame_pkg;
  typedef enum logic [2:0] {HUNT0, HUNT1, CMD, LEN, PAYLOAD, CHK, DRAIN} state_t;
  typedef logic [7:0] byte_t;
  localparam byte_t HDR0_DEF = 8'h55;
  localparam byte_t HDR1_DEF = 8'hAA;
endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: payload store, synchronous write port and combinational read port.
module uart_frame_buf
  import uart_frame_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          sysclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  byte_t         wdata,
  input  logic [AW-1:0] raddr,
  output byte_t         rdata
);
  byte_t mem [DEPTH];
  always_ff @(posedge sysclk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: header hunt, cmd/len/payload/checksum capture and payload drain stream.
// Define UART_FRAME_TIMEOUT_EN to abort partial frames after TIMEOUT_CYC idle cycles.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int    MAX_LEN     = 16,
  parameter byte_t HDR0        = HDR0_DEF,
  parameter byte_t HDR1        = HDR1_DEF,
  parameter int    TIMEOUT_CYC = 8680
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       frame_valid,
  output logic [7:0] frame_cmd,
  output logic [7:0] frame_len,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_ovr,
  output logic       err_tmo
);
  localparam int    AW    = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam byte_t MAX_B = byte_t'(MAX_LEN);
  state_t state, state_n;
  byte_t  cmd, len, sum, wr_ptr, rd_ptr, rd_byte;
  logic   fv_n, ec_n, el_n, eo_n, tmo_hit;
  uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .sysclk (sysclk),
    .we     (rx_valid && state == PAYLOAD),
    .waddr  (wr_ptr[AW-1:0]),
    .wdata  (rx_data),
    .raddr  (rd_ptr[AW-1:0]),
    .rdata  (rd_byte)
  );
  assign out_valid = state == DRAIN;
  assign out_data  = out_valid ? rd_byte : 8'h00;
  assign out_last  = out_valid && rd_ptr == len - 8'd1;
`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_run;
  assign tmo_run = state inside {CMD, LEN, PAYLOAD, CHK};
  assign tmo_hit = tmo_run && !rx_valid && tmo_cnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge sysclk) tmo_cnt <= (rst || rx_valid || !tmo_run) ? '0 : tmo_cnt + 1'b1;
`else
  assign tmo_hit = TIMEOUT_CYC < 0;
`endif
  always_comb begin
    state_n = state;
    fv_n    = 1'b0;
    ec_n    = 1'b0;
    el_n    = 1'b0;
    eo_n    = 1'b0;
    case (state)
      HUNT0:   if (rx_valid && rx_data == HDR0) state_n = HUNT1;
      HUNT1:   if (rx_valid) state_n = rx_data == HDR1 ? CMD : rx_data == HDR0 ? HUNT1 : HUNT0;
      CMD:     if (rx_valid) state_n = LEN;
      LEN: if (rx_valid) begin
        el_n    = rx_data > MAX_B;
        state_n = el_n ? HUNT0 : rx_data == 8'd0 ? CHK : PAYLOAD;
      end
      PAYLOAD: if (rx_valid && wr_ptr == len - 8'd1) state_n = CHK;
      CHK: if (rx_valid) begin
        fv_n    = rx_data == sum;
        ec_n    = !fv_n;
        state_n = (fv_n && len != 8'd0) ? DRAIN : HUNT0;
      end
      DRAIN: begin
        eo_n = rx_valid;
        if (out_ready && out_last) state_n = HUNT0;
      end
      default: state_n = HUNT0;
    endcase
    if (tmo_hit) state_n = HUNT0;
  end
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state       <= HUNT0;
      cmd         <= '0;
      len         <= '0;
      sum         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      frame_cmd   <= '0;
      frame_len   <= '0;
      frame_valid <= 1'b0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_ovr     <= 1'b0;
      err_tmo     <= 1'b0;
    end else begin
      state       <= state_n;
      frame_valid <= fv_n;
      err_chk     <= ec_n;
      err_len     <= el_n;
      err_ovr     <= eo_n;
      err_tmo     <= tmo_hit;
      if (rx_valid)
        case (state)
          CMD: begin
            cmd <= rx_data;
            sum <= rx_data;
          end
          LEN: begin
            len    <= rx_data;
            sum    <= sum + rx_data;
            wr_ptr <= '0;
          end
          PAYLOAD: begin
            sum    <= sum + rx_data;
            wr_ptr <= wr_ptr + 8'd1;
          end
          default: ;
        endcase
      if (fv_n) begin
        frame_cmd <= cmd;
        frame_len <= len;
        rd_ptr    <= '0;
      end
      if (out_valid && out_ready) rd_ptr <= rd_ptr + 8'd1;
    end
  end
endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-stream framing stage directly downstream of the UART receiver. It consumes the receiver's byte/valid pulses and hunts for a two-byte header. It then captures a command byte, a length byte, up to MAX_LEN payload bytes and an 8-bit additive checksum. Validated frames are announced with a one-cycle pulse, and their payload is drained through a valid/ready stream to the command-handling logic.

## Interface
- MAX_LEN, 16: maximum payload bytes per frame (1..255); sets buffer depth.
- HDR0, 8'h55: first header byte.
- HDR1, 8'hAA: second header byte.
- TIMEOUT_CYC, 8680: inter-byte timeout in sysclk cycles (two byte-times at 50 MHz / 115200 baud). Used only with the timeout feature.
- sysclk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle pulse marking rx_data valid.
- frame_valid  out  1  one-cycle pulse: a frame passed its checksum.
- frame_cmd  out  8  command byte of the last good frame; held until the next good frame.
- frame_len  out  8  payload length of the last good frame; held until the next good frame.
- out_data  out  8  payload byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- out_last  out  1  marks the final payload byte.
- err_chk  out  1  one-cycle pulse: checksum mismatch.
- err_len  out  1  one-cycle pulse: length byte > MAX_LEN.
- err_ovr  out  1  one-cycle pulse: byte arrived during DRAIN and was dropped.
- err_tmo  out  1  one-cycle pulse: inter-byte timeout (always 0 when the feature is compiled out).

## Operation
- States: HUNT0, HUNT1, CMD, LEN, PAYLOAD, CHK, DRAIN. A state acts only on a cycle with rx_valid=1, except DRAIN.
- HUNT0: byte==HDR0 → HUNT1; any other byte stays in HUNT0.
- HUNT1:
  - byte==HDR1 → CMD.
  - byte==HDR0 → stay in HUNT1 (resync on 55 55 AA).
  - any other byte → HUNT0.
- CMD: latch cmd; sum=cmd; → LEN.
- LEN:
  - len>MAX_LEN → err_len, → HUNT0.
  - len==0 → CHK.
  - otherwise → PAYLOAD with wr_ptr=0.
  - In all cases sum+=len.
- PAYLOAD: write byte to buf[wr_ptr]; sum+=byte; → CHK when wr_ptr==len-1.
- CHK:
  - byte==sum → frame_valid, load frame_cmd/frame_len; then → DRAIN with rd_ptr=0 if len>0, else → HUNT0.
  - byte!=sum → err_chk, → HUNT0; frame_cmd/frame_len unchanged.
- Checksum arithmetic: sum is 8 bits and wraps modulo 256 over cmd, len and all payload bytes. Headers are excluded.
- DRAIN:
  - out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==len-1).
  - On out_valid&out_ready, rd_ptr increments.
  - The transfer with out_last → HUNT0.
  - rx_valid in DRAIN: byte dropped, err_ovr pulsed, state unchanged.
- Outputs held stable while out_valid=1 and out_ready=0.

## Timing
- Reset: state=HUNT0, all pointers/sum=0, all outputs 0, including frame_cmd and frame_len.
- A reset asserted mid-frame or mid-DRAIN aborts on that edge; out_valid is 0 the next cycle.
- frame_valid, err_chk, err_len and err_ovr assert in the cycle after the edge that samples the triggering byte, for exactly one cycle.
- out_valid first asserts the same cycle as frame_valid.
- Drain throughput: one byte per cycle with out_ready held high. A len-N frame drains in N cycles.
- rx_valid pulses are at least one byte-time apart. No back-to-back input handling is required.

## Configuration
- UART_FRAME_TIMEOUT_EN defined:
  - A counter clears on every accepted rx_valid and counts in CMD, LEN, PAYLOAD and CHK.
  - On reaching TIMEOUT_CYC: err_tmo pulse, → HUNT0, partial frame discarded.
  - The counter is idle in HUNT0, HUNT1 and DRAIN.
- UART_FRAME_TIMEOUT_EN undefined: no counter; err_tmo tied to 0; partial frames wait indefinitely.

## Structure
- Package uart_frame_pkg: state encoding, default HDR0/HDR1 constants.
- Sub-module uart_frame_buf: MAX_LEN×8 payload store with synchronous write port and combinational read port.
- The FSM, checksum, pointers and timeout logic live in uart_frame_parser.

## Test plan
- Good frame: send 55 AA 01 03 10 20 30 64, out_ready=1 → frame_valid once; frame_cmd=01, frame_len=03; out_data 10,20,30 on consecutive cycles with out_last on 30; no err_*.
- Bad checksum: same frame with checksum 65 → err_chk once; no frame_valid; no out_valid; next good frame is accepted.
- Zero length and resync:
  - Send 55 55 AA 07 00 07 → frame_valid with frame_cmd=07, frame_len=00; out_valid never asserts.
  - Send 55 AA 02 11 (len 17, MAX_LEN=16) → err_len after the len byte; parser back in HUNT0.
- Backpressure and overrun:
  - Good 3-byte frame with out_ready=0 for 5 cycles → out_data=10 stable, out_valid held.
  - Inject an rx byte during DRAIN → err_ovr pulse; drain completes unaffected.
- Timeout (UART_FRAME_TIMEOUT_EN): send 55 AA 01, then idle TIMEOUT_CYC cycles → err_tmo once. A following 55 AA 01 00 01 → frame_valid.
- Reset mid-PAYLOAD: assert rst after 55 AA 01 03 10 → all outputs 0. A subsequent good frame parses normally.
